// File: rtl/hilbert_pkg.sv
// Shared types and default sizing for the hilbert FFT frame sequencer.
package hilbert_pkg;

    localparam int unsigned DEF_N       = 32;
    localparam int unsigned DEF_ADDR_W  = 5;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 256;
    localparam int unsigned DEF_FCNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD,
        WAIT_RDY,
        UNLOAD,
        DONE
    } state_t;

endpackage

// File: rtl/hilbert_mod_cnt.sv
// Clock-enabled modulo-N counter with synchronous clear, increment and terminal-count flag.
module hilbert_mod_cnt
    import hilbert_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ed,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc_c
);

    assign tc_c = (count == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ed) begin
            if (clr) begin
                count <= '0;
            end else if (inc) begin
                count <= tc_c ? '0 : count + W'(1);
            end
        end
    end

endmodule

// File: rtl/hilbert_frame_ctrl.sv
// Frame sequencer for the hilbert FFT core: start/load, wait for RDY with watchdog,
// capture the N output bins into an indexed stream and count finished frames.
module hilbert_frame_ctrl
    import hilbert_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned FCNT_W  = DEF_FCNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ED,
    input  logic              GO,
    output logic              BUSY,
    output logic              FFT_START,
    output logic [ADDR_W-1:0] SRC_ADDR,
    input  logic              FFT_RDY,
    input  logic [DATA_W-1:0] FFT_DOREAL,
    input  logic [DATA_W-1:0] FFT_DOIMAG,
    output logic              OUT_VALID,
    output logic [ADDR_W-1:0] OUT_IDX,
    output logic [DATA_W-1:0] OUT_RE,
    output logic [DATA_W-1:0] OUT_IM,
    output logic              FRAME_DONE,
    output logic              TIMEOUT_ERR,
    output logic [FCNT_W-1:0] FRAME_CNT
);

    localparam int unsigned WD_W = $clog2(TIMEOUT);

    state_t state, state_d;

    logic              rdy_q;
    logic              rdy_rise_c;
    logic [WD_W-1:0]   wd;
    logic [ADDR_W-1:0] idx_cnt;
    logic              src_tc, idx_tc;
    logic              start_q, valid_q, done_q;

    logic src_clr, src_inc, idx_clr, capture;
    logic start_d, done_d, err_set, err_clr, wd_clr, wd_inc;

    assign rdy_rise_c = FFT_RDY & ~rdy_q;

    // Strobes are frozen with the rest of the state, so mask them while ED is low.
    assign FFT_START  = start_q & ED;
    assign OUT_VALID  = valid_q & ED;
    assign FRAME_DONE = done_q & ED;

    hilbert_mod_cnt #(.N(N), .W(ADDR_W)) u_src_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .ed    (ED),
        .clr   (src_clr),
        .inc   (src_inc),
        .count (SRC_ADDR),
        .tc_c  (src_tc)
    );

    hilbert_mod_cnt #(.N(N), .W(ADDR_W)) u_idx_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .ed    (ED),
        .clr   (idx_clr),
        .inc   (capture),
        .count (idx_cnt),
        .tc_c  (idx_tc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else if (ED) begin
            state <= state_d;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d = state;
        src_clr = 1'b0;
        src_inc = 1'b0;
        idx_clr = 1'b0;
        capture = 1'b0;
        start_d = 1'b0;
        done_d  = 1'b0;
        err_set = 1'b0;
        err_clr = 1'b0;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (GO) begin
                    state_d = START;
                    src_clr = 1'b1;
                    err_clr = 1'b1;
                    start_d = 1'b1;
                end
            end
            START: begin
                state_d = LOAD;
                src_inc = 1'b1;
                idx_clr = 1'b1;
            end
            LOAD: begin
                if (src_tc) begin
                    state_d = WAIT_RDY;
                    wd_clr  = 1'b1;
                end else begin
                    src_inc = 1'b1;
                end
            end
            WAIT_RDY: begin
                wd_inc = 1'b1;
                // A rising RDY on the expiry cycle still wins over the timeout.
                if (rdy_rise_c) begin
                    state_d = UNLOAD;
                    capture = 1'b1;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end
            end
            UNLOAD: begin
                capture = 1'b1;
                if (idx_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, watchdog and RDY edge detector.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUSY        <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            OUT_IDX     <= '0;
            OUT_RE      <= '0;
            OUT_IM      <= '0;
            TIMEOUT_ERR <= 1'b0;
            FRAME_CNT   <= '0;
            rdy_q       <= 1'b0;
            wd          <= '0;
        end else if (ED) begin
            BUSY    <= (state_d != IDLE);
            start_q <= start_d;
            valid_q <= capture;
            done_q  <= done_d;
            rdy_q   <= FFT_RDY;
            if (capture) begin
                OUT_IDX <= idx_cnt;
                OUT_RE  <= FFT_DOREAL;
                OUT_IM  <= FFT_DOIMAG;
            end
            if (err_clr) begin
                TIMEOUT_ERR <= 1'b0;
            end else if (err_set) begin
                TIMEOUT_ERR <= 1'b1;
            end
            if (done_d) begin
                FRAME_CNT <= FRAME_CNT + FCNT_W'(1);
            end
            if (wd_clr) begin
                wd <= '0;
            end else if (wd_inc) begin
                wd <= wd + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hilbert_frame_ctrl.sv
// Directed bench for hilbert_frame_ctrl with a small FFT-core responder and output scoreboard.
module tb_hilbert_frame_ctrl;

    localparam int unsigned N      = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO    = 16;
    localparam int unsigned FCNT_W = 16;
    localparam int          RDY_DLY = 40;

    logic              CLK, RST_N, ED, GO;
    logic              BUSY, FFT_START, FFT_RDY, OUT_VALID, FRAME_DONE, TIMEOUT_ERR;
    logic [ADDR_W-1:0] SRC_ADDR, OUT_IDX;
    logic [DATA_W-1:0] FFT_DOREAL, FFT_DOIMAG, OUT_RE, OUT_IM;
    logic [FCNT_W-1:0] FRAME_CNT;

    int n_checks = 0;
    int n_err    = 0;

    // Shared between the driver and the negedge monitor/core process.
    int   cyc = 0;
    int   n_start = 0;
    int   n_done = 0;
    int   frame_id = 0;
    int   exp_idx = 0;
    int   last_valid_cyc = 0;
    int   last_done_cyc = 0;
    bit   have_done = 0;
    bit   start_prev = 0;
    bit   src_track = 0;
    logic [ADDR_W-1:0] exp_src = '0;
    bit   ed_last = 0;
    bit   b2b = 0;
    bit   no_rdy = 0;
    int   core_phase = 0;
    int   core_timer = 0;
    int   core_bin = 0;

    hilbert_frame_ctrl #(
        .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO), .FCNT_W(FCNT_W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ED          (ED),
        .GO          (GO),
        .BUSY        (BUSY),
        .FFT_START   (FFT_START),
        .SRC_ADDR    (SRC_ADDR),
        .FFT_RDY     (FFT_RDY),
        .FFT_DOREAL  (FFT_DOREAL),
        .FFT_DOIMAG  (FFT_DOIMAG),
        .OUT_VALID   (OUT_VALID),
        .OUT_IDX     (OUT_IDX),
        .OUT_RE      (OUT_RE),
        .OUT_IM      (OUT_IM),
        .FRAME_DONE  (FRAME_DONE),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .FRAME_CNT   (FRAME_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mdl_re(input int f, input int k);
        return 32'h8000_0000 | 32'(f << 8) | 32'(k);
    endfunction

    function automatic logic [31:0] mdl_im(input int f, input int k);
        return 32'(-(f * 100 + k * 3 + 1));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_go();
        GO = 1'b1;
        step();
        GO = 1'b0;
    endtask

    task automatic wait_src(input logic [ADDR_W-1:0] v, input string tag);
        bit hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            if (SRC_ADDR == v) hit = 1;
        end
        check(tag, 64'(hit), 64'(1));
    endtask

    task automatic wait_idx(input logic [ADDR_W-1:0] v, input string tag);
        bit hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            if (OUT_VALID && OUT_IDX == v) hit = 1;
        end
        check(tag, 64'(hit), 64'(1));
    endtask

    task automatic wait_done(input string tag);
        bit hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            if (FRAME_DONE) hit = 1;
        end
        check(tag, 64'(hit), 64'(1));
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ctrl"}, 64'({BUSY, FFT_START, OUT_VALID, FRAME_DONE, TIMEOUT_ERR}), 64'(0));
        check({tag, "_addr"}, 64'({SRC_ADDR, OUT_IDX}), 64'(0));
        check({tag, "_data"}, 64'({OUT_RE, OUT_IM}), 64'(0));
        check({tag, "_fcnt"}, 64'(FRAME_CNT), 64'(0));
    endtask

    // Monitor/scoreboard followed by the FFT-core responder, both evaluated mid-cycle.
    initial begin
        FFT_RDY    = 1'b0;
        FFT_DOREAL = '0;
        FFT_DOIMAG = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST_N) begin
                src_track  = 0;
                exp_idx    = 0;
                have_done  = 0;
                start_prev = 0;
                core_phase = 0;
                FFT_RDY    = 1'b0;
            end else begin
                if (!ED) check("ed_gate", 64'({FFT_START, OUT_VALID, FRAME_DONE}), 64'(0));
                if (FFT_START) begin
                    check("start_width", 64'(start_prev), 64'(0));
                    check("start_addr", 64'(SRC_ADDR), 64'(0));
                    if (b2b && have_done) check("b2b_gap", 64'(cyc - last_done_cyc), 64'(1));
                    n_start++;
                    src_track = 1;
                    exp_src   = '0;
                    exp_idx   = 0;
                end else if (src_track) begin
                    if (ed_last) exp_src = exp_src + ADDR_W'(1);
                    check("src_addr", 64'(SRC_ADDR), 64'(exp_src));
                    if (exp_src == ADDR_W'(N - 1)) src_track = 0;
                end
                if (OUT_VALID) begin
                    check("out_idx", 64'(OUT_IDX), 64'(exp_idx));
                    check("out_re", 64'(OUT_RE), 64'(mdl_re(frame_id, exp_idx)));
                    check("out_im", 64'(OUT_IM), 64'(mdl_im(frame_id, exp_idx)));
                    exp_idx++;
                    last_valid_cyc = cyc;
                end
                if (FRAME_DONE) begin
                    check("done_bins", 64'(exp_idx), 64'(N));
                    check("done_gap", 64'(cyc - last_valid_cyc), 64'(1));
                    n_done++;
                    have_done     = 1;
                    last_done_cyc = cyc;
                end
                start_prev = FFT_START;

                if (core_phase == 1 && ed_last) begin
                    core_timer--;
                    if (core_timer == 0) begin
                        core_phase = 2;
                        core_bin   = 0;
                        FFT_RDY    = 1'b1;
                        FFT_DOREAL = mdl_re(frame_id, core_bin);
                        FFT_DOIMAG = mdl_im(frame_id, core_bin);
                    end
                end else if (core_phase == 2 && ed_last) begin
                    core_bin++;
                    if (core_bin == int'(N)) begin
                        FFT_RDY    = 1'b0;
                        core_phase = 0;
                    end else begin
                        FFT_DOREAL = mdl_re(frame_id, core_bin);
                        FFT_DOIMAG = mdl_im(frame_id, core_bin);
                    end
                end
                if (FFT_START) begin
                    frame_id++;
                    if (!no_rdy) begin
                        core_phase = 1;
                        core_timer = RDY_DLY;
                    end
                end
            end
            ed_last = ED;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int steps;
        RST_N = 1'b0;
        ED    = 1'b1;
        GO    = 1'b0;
        repeat (3) step();
        chk_zero("reset");
        RST_N = 1'b1;
        step();

        // Basic frame
        pulse_go();
        check("go_start", 64'({FFT_START, BUSY}), 64'(3));
        wait_done("basic_done");
        check("basic_fcnt", 64'(FRAME_CNT), 64'(1));
        check("basic_busy", 64'(BUSY), 64'(0));
        repeat (2) step();
        check("re_hold", 64'(OUT_RE), 64'(mdl_re(frame_id, N - 1)));
        check("valid_idle", 64'(OUT_VALID), 64'(0));

        // GO re-pulsed in LOAD and UNLOAD is ignored
        s0 = n_start;
        pulse_go();
        wait_src(ADDR_W'(5), "repulse_load_wait");
        pulse_go();
        wait_idx(ADDR_W'(3), "repulse_unload_wait");
        pulse_go();
        wait_done("repulse_done");
        check("repulse_fcnt", 64'(FRAME_CNT), 64'(2));
        repeat (3) step();
        check("repulse_starts", 64'(n_start - s0), 64'(1));
        check("repulse_idle", 64'(BUSY), 64'(0));

        // ED gaps in LOAD and UNLOAD
        pulse_go();
        wait_src(ADDR_W'(10), "gap_load_wait");
        ED = 1'b0;
        repeat (3) step();
        check("gap_src_hold", 64'(SRC_ADDR), 64'(10));
        ED = 1'b1;
        wait_idx(ADDR_W'(5), "gap_unload_wait");
        ED = 1'b0;
        repeat (3) step();
        check("gap_idx_hold", 64'(OUT_IDX), 64'(5));
        ED = 1'b1;
        wait_done("gap_done");
        check("gap_fcnt", 64'(FRAME_CNT), 64'(3));

        // Watchdog timeout with RDY never raised
        no_rdy = 1;
        pulse_go();
        wait_src(ADDR_W'(N - 1), "tmo_load_wait");
        steps = 0;
        for (int i = 0; i < 100 && !TIMEOUT_ERR; i++) begin
            step();
            steps++;
        end
        check("tmo_cycles", 64'(steps), 64'(TMO + 1));
        check("tmo_busy", 64'(BUSY), 64'(0));
        check("tmo_fcnt", 64'(FRAME_CNT), 64'(3));
        no_rdy = 0;
        repeat (2) step();
        check("tmo_sticky", 64'(TIMEOUT_ERR), 64'(1));
        pulse_go();
        check("tmo_clear", 64'({TIMEOUT_ERR, BUSY}), 64'(1));
        wait_done("post_tmo_done");
        check("post_tmo_fcnt", 64'(FRAME_CNT), 64'(4));

        // Asynchronous reset mid-UNLOAD, then a clean frame
        pulse_go();
        wait_idx(ADDR_W'(12), "rst_unload_wait");
        #2;
        RST_N = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        RST_N = 1'b1;
        step();
        pulse_go();
        wait_done("clean_done");
        check("clean_fcnt", 64'(FRAME_CNT), 64'(1));

        // GO held high for three back-to-back frames
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        s0  = n_start;
        b2b = 1;
        GO  = 1'b1;
        wait_done("b2b_done1");
        wait_done("b2b_done2");
        wait_done("b2b_done3");
        GO = 1'b0;
        check("b2b_fcnt", 64'(FRAME_CNT), 64'(3));
        repeat (5) step();
        check("b2b_starts", 64'(n_start - s0), 64'(3));
        check("b2b_idle", 64'(BUSY), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
